fpu_share_arbiter: RTL and testbench

Shares one multi-cycle FPU between two requesters, e.g. the integer pipeline and a vector/helper unit. Each requester uses a valid/ready request channel and a valid/ready response channel. The arbiter grants requesters round-robin, issues a one-cycle enable to the FPU, and holds the opcode and operands stable while the FPU counts down. It then captures the result on the FPU ready pulse and returns it to the granted requester. Illegal opcodes and hung operations are reported through an error flag.

---
 rtl/fpu_share_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one multi-cycle FPU between two valid/ready requesters.
// state | meaning: IDLE accept request | ISSUE fpu_en strobe | WAIT count down for fpu_ready | RESP hold result for owner
module fpu_share_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CTL_MAX = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_ctl,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_ctl,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_data,
  output logic        resp0_err,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_data,
  output logic        resp1_err,
  output logic        fpu_en,
  output logic [4:0]  fpu_ctl,
  output logic [31:0] fpu_x1,
  output logic [31:0] fpu_x2,
  input  logic [31:0] fpu_y,
  input  logic        fpu_ready,
  output logic        busy
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    ctl_q, ctl_d;
  logic [31:0]   x1_q, x1_d, x2_q, x2_d;
  logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          rerr0_q, rerr0_d, rerr1_q, rerr1_d;

  logic          grant;
  logic          hs;
  logic [4:0]    sel_ctl;
  logic [31:0]   sel_x1, sel_x2;
  logic          cap_en, cap_who, cap_err;
  logic [31:0]   cap_data;

  // With both valid, the requester that did not win last time goes next.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == S_IDLE) && req1_valid && grant;
  assign hs         = req0_ready || req1_ready;
  assign sel_ctl    = grant ? req1_ctl : req0_ctl;
  assign sel_x1     = grant ? req1_x1  : req0_x1;
  assign sel_x2     = grant ? req1_x2  : req0_x2;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    ctl_d        = ctl_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    cap_en       = 1'b0;
    cap_who      = owner_q;
    cap_data     = 32'd0;
    cap_err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          ctl_d        = sel_ctl;
          x1_d         = sel_x1;
          x2_d         = sel_x2;
          owner_d      = grant;
          last_grant_d = grant;
          if (sel_ctl > 5'(CTL_MAX)) begin
            cap_en  = 1'b1;
            cap_who = grant;
            cap_err = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        timer_d = TW'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A ready pulse on the expiry cycle still counts as a good result.
        if (fpu_ready) begin
          cap_en   = 1'b1;
          cap_data = fpu_y;
          state_d  = S_RESP;
        end else if (timer_q == '0) begin
          cap_en  = 1'b1;
          cap_err = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_RESP: begin
        if (owner_q ? resp1_ready : resp0_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata0_d = rdata0_q;
    rerr0_d  = rerr0_q;
    rdata1_d = rdata1_q;
    rerr1_d  = rerr1_q;
    if (cap_en && !cap_who) begin
      rdata0_d = cap_data;
      rerr0_d  = cap_err;
    end
    if (cap_en && cap_who) begin
      rdata1_d = cap_data;
      rerr1_d  = cap_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      ctl_q        <= 5'd0;
      x1_q         <= 32'd0;
      x2_q         <= 32'd0;
      rdata0_q     <= 32'd0;
      rerr0_q      <= 1'b0;
      rdata1_q     <= 32'd0;
      rerr1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      ctl_q        <= ctl_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      rdata0_q     <= rdata0_d;
      rerr0_q      <= rerr0_d;
      rdata1_q     <= rdata1_d;
      rerr1_q      <= rerr1_d;
    end
  end

  assign fpu_en      = (state_q == S_ISSUE);
  assign fpu_ctl     = ctl_q;
  assign fpu_x1      = x1_q;
  assign fpu_x2      = x2_q;
  assign busy        = (state_q != S_IDLE);
  assign resp0_valid = (state_q == S_RESP) && !owner_q;
  assign resp1_valid = (state_q == S_RESP) && owner_q;
  assign resp0_data  = rdata0_q;
  assign resp0_err   = rerr0_q;
  assign resp1_data  = rdata1_q;
  assign resp1_err   = rerr1_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
`timescale 1ns/1ps
// Bench for fpu_share_arbiter: behavioural FPU model, per-requester scoreboards, scenario tasks.
module tb_fpu_share_arbiter;

  localparam logic [4:0] OP_FADD = 5'd0, OP_FSUB = 5'd1, OP_FMUL = 5'd2, OP_FDIV = 5'd3;
  localparam logic [4:0] OP_SQRT = 5'd4, OP_FNEG = 5'd6, OP_FLOOR = 5'd11, OP_FTOI = 5'd12;
  localparam logic [4:0] OP_ITOF = 5'd13, OP_FINV = 5'd14, OP_FSQR = 5'd20;

  typedef struct packed {logic [31:0] d; logic e;} exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [4:0]  req0_ctl = 5'd0, req1_ctl = 5'd0;
  logic [31:0] req0_x1 = 32'd0, req0_x2 = 32'd0, req1_x1 = 32'd0, req1_x2 = 32'd0;
  logic        resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [31:0] resp0_data, resp1_data;
  logic        fpu_en, fpu_ready, mdl_ready, busy;
  logic        inj_ready = 1'b0;
  logic [4:0]  fpu_ctl;
  logic [31:0] fpu_x1, fpu_x2, fpu_y;

  int checks = 0, errors = 0, cyc = 0;
  exp_t exp0_q[$], exp1_q[$];
  exp_t e0, e1;

  assign fpu_ready = mdl_ready | inj_ready;

  fpu_share_arbiter #(.TIMEOUT(15), .CTL_MAX(20)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl), .req0_x1(req0_x1), .req0_x2(req0_x2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl), .req1_x1(req1_x1), .req1_x2(req1_x2),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_err(resp1_err),
    .fpu_en(fpu_en), .fpu_ctl(fpu_ctl), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
    .fpu_y(fpu_y), .fpu_ready(fpu_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Single-precision <-> real via double bit patterns; normal numbers and zero only.
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      OP_FADD: return r2s(s2r(a) + s2r(b));
      OP_FSUB: return r2s(s2r(a) - s2r(b));
      OP_FMUL: return r2s(s2r(a) * s2r(b));
      OP_FNEG: return a ^ 32'h8000_0000;
      default: return a ^ {b[15:0], b[31:16]} ^ {27'd0, c};
    endcase
  endfunction

  function automatic int nstage(input logic [4:0] c);
    case (c)
      OP_FADD, OP_FSUB:          return 4;
      OP_FMUL, OP_FINV:          return 3;
      OP_FDIV:                   return 7;
      OP_SQRT:                   return 5;
      OP_FLOOR:                  return 1;
      OP_FTOI, OP_ITOF, OP_FSQR: return 2;
      default:                   return 0;
    endcase
  endfunction

  // FPU model: result pulse in cycle en+1+NSTAGE; hang suppresses it, force_lat overrides latency.
  logic        hang = 1'b0;
  int          force_lat = -1;
  int          m_cnt, m_lat;
  logic        m_pend;
  logic [31:0] m_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_ready <= 1'b0; fpu_y <= 32'd0; m_cnt <= 0; m_pend <= 1'b0; m_res <= 32'd0;
    end else begin
      mdl_ready <= 1'b0;
      if (fpu_en && !hang) begin
        m_lat = (force_lat >= 0) ? force_lat : nstage(fpu_ctl);
        if (m_lat == 0) begin
          mdl_ready <= 1'b1;
          fpu_y     <= fpu_fn(fpu_ctl, fpu_x1, fpu_x2);
        end else begin
          m_cnt  <= m_lat;
          m_pend <= 1'b1;
          m_res  <= fpu_fn(fpu_ctl, fpu_x1, fpu_x2);
        end
      end else if (m_pend) begin
        if (m_cnt == 1) begin
          mdl_ready <= 1'b1;
          fpu_y     <= m_res;
          m_pend    <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && resp0_valid && resp0_ready) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL resp0_unexpected data=%h err=%b", resp0_data, resp0_err);
      end else begin
        e0 = exp0_q.pop_front();
        if ({resp0_data, resp0_err} !== {e0.d, e0.e}) begin
          errors++;
          $display("FAIL resp0_result got data=%h err=%b exp data=%h err=%b", resp0_data, resp0_err, e0.d, e0.e);
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && resp1_valid && resp1_ready) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL resp1_unexpected data=%h err=%b", resp1_data, resp1_err);
      end else begin
        e1 = exp1_q.pop_front();
        if ({resp1_data, resp1_err} !== {e1.d, e1.e}) begin
          errors++;
          $display("FAIL resp1_result got data=%h err=%b exp data=%h err=%b", resp1_data, resp1_err, e1.d, e1.e);
        end
      end
    end
  end

  // Operands seen at the fpu_en strobe must hold until the response appears.
  logic        watching = 1'b0;
  logic [68:0] snap;
  always @(negedge clk) begin
    #2;
    if (rst || !busy) watching = 1'b0;
    else if (fpu_en) begin
      watching = 1'b1;
      snap = {fpu_ctl, fpu_x1, fpu_x2};
    end else if (watching && !resp0_valid && !resp1_valid) begin
      checks++;
      if ({fpu_ctl, fpu_x1, fpu_x2} !== snap) begin
        errors++;
        $display("FAIL wait_operands_stable got=%h exp=%h", {fpu_ctl, fpu_x1, fpu_x2}, snap);
      end
    end else watching = 1'b0;
  end

  task automatic push_exp(input int n, input logic [31:0] d, input logic e);
    exp_t x;
    x.d = d;
    x.e = e;
    if (n == 0) exp0_q.push_back(x);
    else exp1_q.push_back(x);
  endtask

  task automatic drive_req(input int n, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                           output int t_hs, output bit ok);
    ok = 1'b0;
    t_hs = -1;
    @(negedge clk);
    if (n == 0) begin req0_valid = 1'b1; req0_ctl = c; req0_x1 = a; req0_x2 = b; end
    else begin req1_valid = 1'b1; req1_ctl = c; req1_x1 = a; req1_x2 = b; end
    for (int k = 0; k < 200; k++) begin
      #1;
      if (((n == 0) ? req0_ready : req1_ready) === 1'b1) begin
        t_hs = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    if (n == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Observe `len` cycles after a handshake: fpu_en count and first cycle, first response cycles.
  int w_en_cnt, w_en_cyc, w_r0, w_r1;
  task automatic watch(input int len);
    w_en_cnt = 0; w_en_cyc = -1; w_r0 = -1; w_r1 = -1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (fpu_en === 1'b1) begin
        w_en_cnt++;
        if (w_en_cyc < 0) w_en_cyc = cyc;
      end
      if (resp0_valid === 1'b1 && w_r0 < 0) w_r0 = cyc;
      if (resp1_valid === 1'b1 && w_r1 < 0) w_r1 = cyc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1; resp1_ready = 1'b1;
    hang = 1'b0; force_lat = -1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({busy, fpu_en, resp0_valid, resp1_valid, resp0_err, resp1_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000000", {busy, fpu_en, resp0_valid, resp1_valid, resp0_err, resp1_err});
    end
    checks++;
    if ({fpu_ctl, fpu_x1, fpu_x2, resp0_data, resp1_data} !== 133'd0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {fpu_ctl, fpu_x1, fpu_x2, resp0_data, resp1_data});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fadd();
    int t; bit ok;
    push_exp(0, 32'h4040_0000, 1'b0);
    drive_req(0, OP_FADD, 32'h3F80_0000, 32'h4000_0000, t, ok);
    watch(12);
    checks++;
    if (!ok || w_en_cnt != 1 || w_en_cyc != t + 1) begin
      errors++;
      $display("FAIL fadd_fpu_en got count=%0d at=%0d exp count=1 at=%0d", w_en_cnt, w_en_cyc, t + 1);
    end
    checks++;
    if (w_r0 != t + 7) begin
      errors++;
      $display("FAIL fadd_latency got=%0d exp=%0d", w_r0, t + 7);
    end
    checks++;
    if (w_r1 != -1) begin
      errors++;
      $display("FAIL fadd_resp1_idle got resp1_valid at=%0d exp never", w_r1);
    end
  endtask

  task automatic test_fneg();
    int t; bit ok;
    push_exp(1, 32'hBF80_0000, 1'b0);
    drive_req(1, OP_FNEG, 32'h3F80_0000, 32'd0, t, ok);
    watch(8);
    checks++;
    if (!ok || w_r1 != t + 3 || w_r0 != -1) begin
      errors++;
      $display("FAIL fneg_latency got resp1=%0d resp0=%0d exp resp1=%0d resp0=-1", w_r1, w_r0, t + 3);
    end
  endtask

  task automatic test_illegal();
    int t; bit ok;
    push_exp(0, 32'd0, 1'b1);
    drive_req(0, 5'd25, 32'h1234_5678, 32'h9ABC_DEF0, t, ok);
    watch(6);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL illegal_ready got req0_ready=0 exp=1");
    end
    checks++;
    if (w_en_cnt != 0 || w_r0 != t + 1) begin
      errors++;
      $display("FAIL illegal_timing got en=%0d resp0=%0d exp en=0 resp0=%0d", w_en_cnt, w_r0, t + 1);
    end
  endtask

  int rr_t0, rr_t1;
  bit rr_ok0, rr_ok1;
  task automatic test_round_robin();
    bit ok; int t;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      push_exp(0, fpu_fn(OP_FMUL, 32'h4040_0000, 32'h4000_0000), 1'b0);
      push_exp(1, fpu_fn(OP_FMUL, 32'h3F00_0000, 32'h4100_0000), 1'b0);
      fork
        drive_req(0, OP_FMUL, 32'h4040_0000, 32'h4000_0000, rr_t0, rr_ok0);
        drive_req(1, OP_FMUL, 32'h3F00_0000, 32'h4100_0000, rr_t1, rr_ok1);
      join
      checks++;
      if (!(rr_ok0 && rr_ok1) || rr_t1 != rr_t0 + 7) begin
        errors++;
        $display("FAIL rr_pair%0d_req0_first got t0=%0d t1=%0d exp t1=t0+7", p, rr_t0, rr_t1);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_idle got busy=1 exp busy=0"); end
    end
    push_exp(0, fpu_fn(OP_FNEG, 32'h4110_0000, 32'd0), 1'b0);
    drive_req(0, OP_FNEG, 32'h4110_0000, 32'd0, t, ok);
    wait_idle(ok);
    push_exp(0, fpu_fn(OP_FMUL, 32'h4080_0000, 32'h4080_0000), 1'b0);
    push_exp(1, fpu_fn(OP_FMUL, 32'h3FC0_0000, 32'h4000_0000), 1'b0);
    fork
      drive_req(0, OP_FMUL, 32'h4080_0000, 32'h4080_0000, rr_t0, rr_ok0);
      drive_req(1, OP_FMUL, 32'h3FC0_0000, 32'h4000_0000, rr_t1, rr_ok1);
    join
    checks++;
    if (!(rr_ok0 && rr_ok1) || rr_t0 != rr_t1 + 7) begin
      errors++;
      $display("FAIL rr_req1_first got t0=%0d t1=%0d exp t0=t1+7", rr_t0, rr_t1);
    end
    wait_idle(ok);
  endtask

  task automatic test_timeout();
    int t; bit ok;
    hang = 1'b1;
    push_exp(0, 32'd0, 1'b1);
    drive_req(0, OP_FADD, 32'h3F80_0000, 32'h3F80_0000, t, ok);
    watch(25);
    checks++;
    if (!ok || w_en_cnt != 1 || w_r0 != t + 17) begin
      errors++;
      $display("FAIL timeout_abort got en=%0d resp0=%0d exp en=1 resp0=%0d", w_en_cnt, w_r0, t + 17);
    end
    hang = 1'b0;
    force_lat = 14;
    push_exp(0, fpu_fn(OP_FMUL, 32'h4040_0000, 32'h4040_0000), 1'b0);
    drive_req(0, OP_FMUL, 32'h4040_0000, 32'h4040_0000, t, ok);
    watch(25);
    checks++;
    if (!ok || w_r0 != t + 17) begin
      errors++;
      $display("FAIL timeout_ready_wins got resp0=%0d exp=%0d", w_r0, t + 17);
    end
    force_lat = 15;
    push_exp(0, 32'd0, 1'b1);
    drive_req(0, OP_FSUB, 32'h4040_0000, 32'h3F80_0000, t, ok);
    watch(25);
    checks++;
    if (!ok || w_r0 != t + 17) begin
      errors++;
      $display("FAIL timeout_late_ready got resp0=%0d exp=%0d", w_r0, t + 17);
    end
    force_lat = -1;
  endtask

  task automatic test_stale_ready();
    int t; bit ok;
    @(negedge clk);
    inj_ready = 1'b1;
    @(negedge clk);
    inj_ready = 1'b0;
    #1;
    checks++;
    if ({busy, resp0_valid, resp1_valid} !== 3'b000) begin
      errors++;
      $display("FAIL stale_ready_idle got=%b exp=000", {busy, resp0_valid, resp1_valid});
    end
    push_exp(1, fpu_fn(OP_FLOOR, 32'h4049_0FDB, 32'h0000_0001), 1'b0);
    drive_req(1, OP_FLOOR, 32'h4049_0FDB, 32'h0000_0001, t, ok);
    watch(8);
    checks++;
    if (!ok || w_r1 != t + 4) begin
      errors++;
      $display("FAIL floor_latency got resp1=%0d exp=%0d", w_r1, t + 4);
    end
  endtask

  task automatic test_stall_reset();
    int t, r; bit ok; logic [31:0] d;
    resp0_ready = 1'b0;
    push_exp(0, 32'hC000_0000, 1'b0);
    drive_req(0, OP_FNEG, 32'h4000_0000, 32'd0, t, ok);
    req1_valid = 1'b1; req1_ctl = OP_FADD; req1_x1 = 32'h3F80_0000; req1_x2 = 32'h3F80_0000;
    r = -1;
    for (int k = 0; k < 20 && r < 0; k++) begin
      @(negedge clk);
      if (resp0_valid === 1'b1) r = cyc;
    end
    checks++;
    if (!ok || r != t + 3) begin
      errors++;
      $display("FAIL stall_first_resp got=%0d exp=%0d", r, t + 3);
    end
    d = resp0_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({resp0_valid, resp0_data, req1_ready} !== {1'b1, d, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold got valid=%b data=%h req1_ready=%b exp 1 %h 0", resp0_valid, resp0_data, req1_ready, d);
      end
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL req1_after_resp got=%b exp=1", req1_ready);
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, fpu_en} !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset_wait got busy,en=%b exp=10", {busy, fpu_en});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, fpu_en, resp0_data} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%b en=%b data=%h exp 0 0 0", busy, fpu_en, resp0_data);
    end
    @(negedge clk);
    rst = 1'b0;
    watch(15);
    checks++;
    if (w_r0 != -1 || w_r1 != -1 || w_en_cnt != 0) begin
      errors++;
      $display("FAIL reset_discard got resp0=%0d resp1=%0d en=%0d exp none", w_r0, w_r1, w_en_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fneg();
    test_illegal();
    test_round_robin();
    test_timeout();
    test_stale_ready();
    test_stall_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got pending0=%0d pending1=%0d exp 0 0", exp0_q.size(), exp1_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
